// File: rtl/io_port_if.sv
// io_port_if: bundle between the IO port unit and its surroundings.
// The master side is the control unit plus the external input/output devices;
// the slave side is io_port_unit.
//   out_write/out_data     : OUT instruction strobe and the word to emit
//   in_read/in_data        : IN instruction strobe and the registered result
//   ext_in_*               : valid/ready push from the external input device
//   ext_out_*              : valid/ready drain to the external sink
//   overflow/underflow     : sticky error flags
interface io_port_if;
  logic        out_write;
  logic [15:0] out_data;
  logic        in_read;
  logic [15:0] in_data;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic        overflow;
  logic        underflow;

  modport master (
    output out_write, out_data, in_read, ext_in_data, ext_in_valid, ext_out_ready,
    input  in_data, ext_in_ready, ext_out_data, ext_out_valid, overflow, underflow
  );

  modport slave (
    input  out_write, out_data, in_read, ext_in_data, ext_in_valid, ext_out_ready,
    output in_data, ext_in_ready, ext_out_data, ext_out_valid, overflow, underflow
  );
endinterface

// File: rtl/io_port_unit.sv
// io_port_unit: two 4x16 FIFOs between the CPU datapath and external devices.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; flushes both FIFOs and clears the flags
//   io    : io_port_if.slave (see io_port_if for the signal list)
// Input path : external push -> input FIFO -> InputRead loads in_data.
// Output path: OutputWrite -> output FIFO -> external valid/ready drain.

// 4-entry FIFO, head is combinational from storage.
module io_port_fifo (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] head,
  output logic [2:0]  count
);
  logic [15:0] mem [4];
  logic [1:0]  rptr, wptr;

  assign head = mem[rptr];

  // Storage is not reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= 2'd0;
      wptr  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end
endmodule

module io_port_unit (
  input  logic       clk,
  input  logic       reset,
  io_port_if.slave   io
);
  logic [15:0] in_head, out_head;
  logic [2:0]  in_count, out_count;
  logic        in_push, in_pop, out_push, out_pop;
  logic [15:0] in_data_q;
  logic        ovf_q, udf_q;

  // Input path. A pop on an empty FIFO is not a pop: a same-cycle push is
  // stored, never bypassed to in_data.
  assign io.ext_in_ready = !reset && (in_count != 3'd4);
  assign in_push         = io.ext_in_valid && io.ext_in_ready;
  assign in_pop          = io.in_read && (in_count != 3'd0);

  // Output path. When full, a same-cycle drain frees the slot being written:
  // wptr == rptr, and the head word has already left at this edge.
  assign io.ext_out_valid = (out_count != 3'd0);
  assign io.ext_out_data  = out_head;
  assign out_pop          = io.ext_out_valid && io.ext_out_ready;
  assign out_push         = io.out_write && ((out_count != 3'd4) || out_pop);

  io_port_fifo u_in_fifo (
    .clk(clk), .reset(reset), .push(in_push), .pop(in_pop),
    .din(io.ext_in_data), .head(in_head), .count(in_count)
  );

  io_port_fifo u_out_fifo (
    .clk(clk), .reset(reset), .push(out_push), .pop(out_pop),
    .din(io.out_data), .head(out_head), .count(out_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_data_q <= 16'h0000;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      if (io.in_read) begin
        in_data_q <= in_pop ? in_head : 16'h0000;
        if (!in_pop) udf_q <= 1'b1;
      end
      if (io.out_write && !out_push) ovf_q <= 1'b1;
    end
  end

  assign io.in_data   = in_data_q;
  assign io.overflow  = ovf_q;
  assign io.underflow = udf_q;
endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  io_port_if bus ();

  io_port_unit dut (.clk(clk), .reset(reset), .io(bus.slave));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int in_cnt = 0;            // bench occupancy model of the input FIFO
  logic [15:0] out_q [$];    // scoreboard: words expected on ext_out_data

  typedef struct {
    logic        ow;
    logic [15:0] od;
    logic        ir;
    logic [15:0] eid;
    logic        eiv;
    logic        eor;
    logic [15:0] e_in;
    logic        e_uf;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs against the scoreboard,
  // advance the models, then check registered outputs after the edge.
  task automatic step(input logic ow, input logic [15:0] od, input logic ir,
                      input logic [15:0] eid, input logic eiv, input logic eor,
                      input logic [15:0] e_in, input logic e_uf, input logic e_ovf);
    logic acc;
    logic [15:0] w;
    bus.out_write = ow;  bus.out_data = od;  bus.in_read = ir;
    bus.ext_in_data = eid; bus.ext_in_valid = eiv; bus.ext_out_ready = eor;
    #1;
    chk("ext_in_ready", bus.ext_in_ready, in_cnt != 4);
    chk("ext_out_valid", bus.ext_out_valid, out_q.size() != 0);
    if (eor && out_q.size() != 0) begin
      w = out_q.pop_front();
      chk("ext_out_data", bus.ext_out_data, w);
    end
    acc = eiv && (in_cnt != 4);
    if (ir && in_cnt > 0) in_cnt--;
    if (acc) in_cnt++;
    if (ow && out_q.size() < 4) out_q.push_back(od);
    @(posedge clk); #1;
    chk("in_data", bus.in_data, e_in);
    chk("underflow", bus.underflow, e_uf);
    chk("overflow", bus.overflow, e_ovf);
  endtask

  task automatic do_reset(input logic act);
    reset = 1'b1;
    bus.out_write = act; bus.out_data = 16'hDEAD; bus.in_read = act;
    bus.ext_in_data = 16'hDEAD; bus.ext_in_valid = act; bus.ext_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst in_data", bus.in_data, 16'h0000);
    chk("rst underflow", bus.underflow, 1'b0);
    chk("rst overflow", bus.overflow, 1'b0);
    chk("rst ext_out_valid", bus.ext_out_valid, 1'b0);
    chk("rst ext_in_ready", bus.ext_in_ready, 1'b0);
    reset = 1'b0;
    bus.out_write = 1'b0; bus.in_read = 1'b0; bus.ext_in_valid = 1'b0;
    in_cnt = 0;
    out_q.delete();
    #1;
    chk("post-rst ext_in_ready", bus.ext_in_ready, 1'b1);
  endtask

  initial begin
    //         ow   od        ir   eid       eiv  eor  e_in      uf   ovf
    vecs[0]  = '{1'b0, 16'h0,    1'b0, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0,    1'b0, 16'h2222, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h1111, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h2222, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b0, 16'h2222, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'h0,    1'b0, 16'h3333, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h3333, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 16'h0,    1'b1, 16'h4444, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h4444, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'h5555, 1'b0, 16'h0,    1'b0, 1'b0, 16'h4444, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h4444, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h4444, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0,    1'b0, 16'h6666, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0,    1'b1, 16'h7777, 1'b1, 1'b0, 16'h6666, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h7777, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h7777, 1'b1, 1'b0};

    do_reset(1'b0);
    foreach (vecs[i])
      step(vecs[i].ow, vecs[i].od, vecs[i].ir, vecs[i].eid, vecs[i].eiv, vecs[i].eor,
           vecs[i].e_in, vecs[i].e_uf, vecs[i].e_ovf);

    // Input FIFO full with valid held; read frees a slot, held word lands next.
    do_reset(1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b0, 16'h0, 1'b0, 16'h8001 + 16'(k), 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 16'h8005, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h8005, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      step(1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h8002 + 16'(k), 1'b0, 1'b0);
    chk("in fifo drained ready", bus.ext_in_ready, 1'b1);

    // Five writes into a stalled output FIFO: fifth dropped, then drain.
    do_reset(1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b1, 16'hA000 + 16'(k), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b0, k == 4);
    for (int k = 0; k < 5; k++)
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    chk("out drained valid", bus.ext_out_valid, 1'b0);

    // Write into a full output FIFO while it drains: accepted, emitted last.
    do_reset(1'b0);
    for (int k = 0; k < 4; k++)
      step(1'b1, 16'hC000 + 16'(k), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk("beef drained valid", bus.ext_out_valid, 1'b0);

    // Mid-operation reset with every strobe active flushes both FIFOs.
    do_reset(1'b0);
    step(1'b1, 16'hD000, 1'b0, 16'hE000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'hD001, 1'b0, 16'hE001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'hE000, 1'b0, 1'b0);
    step(1'b0, 16'h0,    1'b0, 16'hE002, 1'b1, 1'b0, 16'hE000, 1'b0, 1'b0);
    do_reset(1'b1);
    step(1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_port_unit.md
IO_PORT_UNIT -- requirements
Module: io_port_unit

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 OutputWrite  input  1  control-unit strobe for OUT instruction; push OutData into output FIFO.
REQ-005 OutData  input  16  register value to be output.
REQ-006 InputRead  input  1  control-unit strobe for IN instruction; pop input FIFO into InData.
REQ-007 InData  output  16  registered word delivered to datapath write-back mux.
REQ-008 ExtInData  input  16  word from external input device.
REQ-009 ExtInValid  input  1  external device offers ExtInData.
REQ-010 ExtInReady  output  1  input FIFO can accept a word.
REQ-011 ExtOutData  output  16  head of output FIFO.
REQ-012 ExtOutValid  output  1  output FIFO non-empty.
REQ-013 ExtOutReady  input  1  external sink accepts ExtOutData.
REQ-014 Overflow  output  1  sticky: OUT word dropped on full output FIFO.
REQ-015 Underflow  output  1  sticky: IN issued on empty input FIFO.

Function
REQ-016 Input FIFO and output FIFO SHALL each be 4 entries x 16 bits, 2-bit read/write pointers wrapping 3->0, 3-bit occupancy count 0..4.
REQ-017 ExtInReady SHALL equal (in_count != 4) and be 0 while Reset is high; push occurs on edge where ExtInValid && ExtInReady.
REQ-018 InputRead with in_count > 0 SHALL load InData with head entry at that edge and advance read pointer; one-cycle latency.
REQ-019 InputRead with in_count == 0 SHALL load InData = 16'h0000 and set Underflow; no bypass of a same-cycle push (push still stored, count becomes 1).
REQ-020 InData SHALL hold its value between InputRead strobes.
REQ-021 Simultaneous external push and InputRead on non-empty, non-full input FIFO: both occur, in_count unchanged.
REQ-022 ExtOutValid SHALL equal (out_count != 0); ExtOutData SHALL be the head entry (combinational from storage, stable while valid && !ready).
REQ-023 Transfer out occurs on edge where ExtOutValid && ExtOutReady; read pointer advances.
REQ-024 OutputWrite with out_count < 4 SHALL store OutData at write pointer; word visible on ExtOutData the cycle after the edge if FIFO was empty.
REQ-025 OutputWrite with out_count == 4 and no same-cycle transfer out SHALL drop the word and set Overflow.
REQ-026 OutputWrite with out_count == 4 and same-cycle transfer out SHALL be accepted; out_count stays 4, Overflow unchanged.
REQ-027 Overflow and Underflow SHALL remain set until Reset.
REQ-028 Ordering SHALL be strict FIFO on both paths; no word duplicated or reordered.

Reset
REQ-029 On Reset high at a rising edge: all pointers and counts = 0, InData = 0, Overflow = 0, Underflow = 0, hence ExtOutValid = 0.
REQ-030 Reset mid-operation SHALL discard all buffered words in both FIFOs; OutputWrite/InputRead/external pushes in the reset cycle are ignored.
REQ-031 ExtInReady SHALL be 1 on the first cycle after Reset deasserts.

Verification
REQ-032 Push 16'h1111, 16'h2222 externally, then InputRead twice -> InData = 16'h1111 then 16'h2222, Underflow = 0.
REQ-033 InputRead on empty input FIFO -> InData = 16'h0000, Underflow = 1, remains 1 after later successful reads.
REQ-034 Push 4 input words with ExtInValid held -> ExtInReady = 0 after 4th; 5th word not accepted; InputRead frees one slot, ExtInReady = 1 next cycle.
REQ-035 ExtOutReady = 0, five OutputWrites of 16'hA000..16'hA004 -> out_count 4, Overflow = 1; then ExtOutReady = 1 -> 16'hA000..16'hA003 emitted in order, ExtOutValid = 0 after.
REQ-036 Output FIFO full, OutputWrite 16'hBEEF with ExtOutReady = 1 same cycle -> accepted, Overflow stays 0, 16'hBEEF emitted last.
REQ-037 Fill both FIFOs with 2 words, assert Reset one cycle -> ExtOutValid = 0, InData = 0, flags = 0, next InputRead gives Underflow = 1.
